// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the
// load unit (source 0) and the ALU (source 1).
//
// Ports
//   clk, rst        clock (rising edge), async active-high reset
//   req_valid[1:0]  per-source request valid (0 = load, 1 = ALU)
//   req_dest0/1     per-source destination register
//   req_data0/1     per-source write data
//   req_ready[1:0]  per-source grant, one-hot or zero, combinational
//   RegWrite        registered register file write enable
//   rg_wrt_dest     registered register file write address
//   rg_wrt_data     registered register file write data
//   starve_cnt      consecutive contested losses of source 1 (debug)
//
// Build option
//   WB_RR_EN  defined: contested cycles alternate (round-robin).
//             undefined: source 0 has fixed priority; only the
//             STARVE_LIMIT override lets source 1 win contention.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_valid,
  input  logic [ADDRESS_WIDTH-1:0] req_dest0,
  input  logic [DATA_WIDTH-1:0]    req_data0,
  input  logic [ADDRESS_WIDTH-1:0] req_dest1,
  input  logic [DATA_WIDTH-1:0]    req_data1,
  output logic [1:0]               req_ready,
  output logic                     RegWrite,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data,
  output logic [3:0]               starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic                     last_grant;
  logic [1:0]               grant;
  logic                     force1;
  logic                     pick1;
  logic                     xfer;
  logic [ADDRESS_WIDTH-1:0] sel_dest;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [3:0]               starve_nxt;

  // Source 1 is forced through once it has lost LIMIT times in a row.
  assign force1 = (starve_cnt == LIMIT);

`ifdef WB_RR_EN
  // Contested: grant the source opposite to the previous winner.
  assign pick1 = force1 | ~last_grant;
`else
  assign pick1 = force1;
`endif

  // Grant is suppressed while reset is held, even though the
  // registers are already cleared, so no requester sees a transfer.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = pick1 ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    sel_dest = req_dest0;
    sel_data = req_data0;
    if (grant[1]) begin
      sel_dest = req_dest1;
      sel_data = req_data1;
    end
  end

  // Losses only count while source 1 keeps asking and source 0 wins.
  always_comb begin
    starve_nxt = starve_cnt;
    if (grant[1] || !req_valid[1]) begin
      starve_nxt = 4'd0;
    end else if (req_valid == 2'b11 && grant[0]) begin
      if (starve_cnt != LIMIT) begin
        starve_nxt = starve_cnt + 4'd1;
      end
    end
  end

  // x0 writes are accepted and retired without asserting RegWrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite    <= 1'b0;
      rg_wrt_dest <= '0;
      rg_wrt_data <= '0;
    end else begin
      RegWrite <= xfer && (sel_dest != '0);
      if (xfer) begin
        rg_wrt_dest <= sel_dest;
        rg_wrt_data <= sel_data;
      end
    end
  end

  // last_grant resets to 1 so source 0 wins the first contested
  // round-robin cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
      last_grant <= 1'b1;
    end else begin
      starve_cnt <= starve_nxt;
      if (xfer) begin
        last_grant <= grant[1];
      end
    end
  end

endmodule
